// File: rtl/serial_adder_seq.sv
// Bit-serial adder: captures two WIDTH-bit operands on start, adds them LSB-first
// through a 1-bit sum/carry cell with a registered carry, then pulses done with {cout,sum}.
module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_r, b_r, sum_r;
   logic             c;
   logic [CW-1:0]    cnt;

   logic             s, c_nxt;
   logic             load, shift_en, last_bit;

   // Single-bit full-add cell on the current operand LSBs.
   assign s     = a_r[0] ^ b_r[0] ^ c;
   assign c_nxt = (a_r[0] & b_r[0]) | (c & (a_r[0] ^ b_r[0]));

   assign shift_en = (state == SHIFT);
   assign last_bit = shift_en && (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_next = state;
      load       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            // A start seen in DONE launches the next add with no idle bubble.
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         sum_r <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= state_next;
         if (load) begin
            a_r   <= a;
            b_r   <= b;
            sum_r <= '0;
            c     <= 1'b0;
            cnt   <= '0;
         end else if (shift_en) begin
            a_r   <= a_r >> 1;
            b_r   <= b_r >> 1;
            sum_r <= {s, sum_r[WIDTH-1:1]};
            c     <= c_nxt;
            cnt   <= cnt + 1'b1;
         end
         // Outputs only move on entry to DONE and hold until the next result.
         if (last_bit) begin
            sum  <= {s, sum_r[WIDTH-1:1]};
            cout <= c_nxt;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq: directed cases plus random ops on WIDTH=8 and WIDTH=3.
module tb_serial_adder_seq;

   logic       clk = 1'b0;
   logic       rst_n, start;
   logic [7:0] a, b, sum;
   logic       busy, done, cout;

   logic       rst3_n, start3;
   logic [2:0] a3, b3, sum3;
   logic       busy3, done3, cout3;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic [8:0] q8[$];
   logic [3:0] q3[$];
   logic [8:0] held8 = '0;
   logic [3:0] held3 = '0;
   bit prev_done8 = 0, prev_done3 = 0;
   bit w3_fin = 0;
   int last_done_cyc = 0;

   serial_adder_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder_seq #(.WIDTH(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .start(start3), .a(a3), .b(b3),
      .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0h (t=%0t)", name, act, $time);
      end
   endtask

   // Monitors: every done pops one expected result; an unexpected done is an error.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done8: got done=1 expected no pending op (t=%0t)", $time);
         end else begin
            check("result8", {23'd0, cout, sum}, {23'd0, q8.pop_front()});
         end
         check("done_width8", {31'd0, prev_done8}, 32'd0);
         check("busy_at_done8", {31'd0, busy}, 32'd0);
         last_done_cyc = cyc;
      end
      prev_done8 = done;
   end

   always @(negedge clk) begin
      if (rst3_n && done3) begin
         if (q3.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done3: got done=1 expected no pending op (t=%0t)", $time);
         end else begin
            check("result3", {28'd0, cout3, sum3}, {28'd0, q3.pop_front()});
         end
         check("done_width3", {31'd0, prev_done3}, 32'd0);
      end
      prev_done3 = done3;
   end

   // Issue one add on the 8-bit DUT; optionally re-pulse start mid-add (must be ignored).
   task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input bit poke);
      int nb;
      bit got;
      logic [8:0] e;
      e = {1'b0, x} + {1'b0, y};
      start = 1'b1; a = x; b = y;
      q8.push_back(e);
      @(posedge clk); #1;
      start = 1'b0; a = 8'($urandom); b = 8'($urandom);
      nb = 0; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
         end else begin
            if (busy) nb++;
            if (nb == 1 || nb == 8) check("hold_during_add8", {23'd0, cout, sum}, {23'd0, held8});
            if (poke) begin
               start = (nb == 3);
               if (nb == 3) begin a = 8'h55; b = 8'h55; end
            end
         end
      end
      start = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL timeout8: got no done expected done within 20 cycles (t=%0t)", $time);
      end
      check("busy_cycles8", nb, 32'd8);
      held8 = e;
   endtask

   task automatic do_op3(input logic [2:0] x, input logic [2:0] y);
      int nb;
      bit got;
      logic [3:0] e;
      e = {1'b0, x} + {1'b0, y};
      start3 = 1'b1; a3 = x; b3 = y;
      q3.push_back(e);
      @(posedge clk); #1;
      start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom);
      nb = 0; got = 0;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         if (done3) got = 1;
         else if (busy3) nb++;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL timeout3: got no done expected done within 12 cycles (t=%0t)", $time);
      end
      if (nb != 3) begin
         checks++; errors++;
         $display("FAIL busy_cycles3: got %0d expected 3 (t=%0t)", nb, $time);
      end
      held3 = e;
   endtask

   // WIDTH=3 random traffic runs in parallel on its own reset.
   initial begin
      rst3_n = 1'b0; start3 = 1'b0; a3 = '0; b3 = '0;
      #3;
      check("reset3_outputs", {27'd0, busy3, done3, cout3, sum3}, 32'd0);
      repeat (3) @(negedge clk);
      rst3_n = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         do_op3(3'($urandom), 3'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            check("idle_hold3", {28'd0, cout3, sum3}, {28'd0, held3});
         end
      end
      w3_fin = 1;
   end

   initial begin
      int t1, t2;
      bit got;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #3;
      check("reset8_outputs", {21'd0, busy, done, cout, sum}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      do_op8(8'h0F, 8'h01, 0);
      repeat (3) @(negedge clk);
      check("idle_hold8", {23'd0, cout, sum}, {23'd0, held8});
      do_op8(8'hFF, 8'h01, 0);
      do_op8(8'hFF, 8'hFF, 0);
      @(negedge clk);
      do_op8(8'h12, 8'h34, 1);
      repeat (4) @(negedge clk);

      // Held start: two back-to-back ops, operands changed after the first is accepted.
      start = 1'b1; a = 8'h01; b = 8'h02; q8.push_back(9'h003);
      @(posedge clk); #1;
      a = 8'h80; b = 8'h80; q8.push_back(9'h100);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (done) got = 1; end
      t1 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); if (done) got = 1; end
      t2 = cyc;
      if (!got) begin
         checks++; errors++;
         $display("FAIL timeout_b2b: got no second done expected one (t=%0t)", $time);
      end
      check("initiation_interval", t2 - t1, 32'd9);
      held8 = 9'h100;
      repeat (2) @(negedge clk);

      // Async reset in the 4th SHIFT cycle aborts the add with no done.
      do_op8(8'hA5, 8'h5A, 0);
      @(negedge clk);
      start = 1'b1; a = 8'h03; b = 8'h04;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {21'd0, busy, done, cout, sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      held8 = '0;
      repeat (15) @(negedge clk);
      check("post_reset_idle", {22'd0, busy, cout, sum}, 32'd0);

      for (int n = 0; n < 1000; n++) begin
         do_op8(8'($urandom), 8'($urandom), 0);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      for (int i = 0; i < 20000 && !w3_fin; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("w3_finished", {31'd0, w3_fin}, 32'd1);
      check("q8_drained", q8.size(), 32'd0);
      check("q3_drained", q3.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got simulation still running expected completion (t=%0t)", $time);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
